// File: rtl/imem_arbiter.sv
// Round-robin burst arbiter letting a fetch port and a load/debug port share one
// combinational-read instruction memory; read data is registered and tagged per requester.
module imem_arbiter #(
    parameter int unsigned AW = 6,
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic [AW-1:0] addr0,
    input  logic [1:0]    len0,
    input  logic          req1,
    input  logic [AW-1:0] addr1,
    input  logic [1:0]    len1,
    output logic          gnt0,
    output logic          gnt1,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] rdata,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic          busy
);

    typedef enum logic [0:0] {StIdle, StBurst} state_e;

    state_e        state_q;
    logic          owner_q;
    logic          last_owner_q;
    logic [AW-1:0] base_q;
    logic [1:0]    beats_left_q;
    logic [1:0]    beat_cnt_q;
    logic          gnt0_q;
    logic          gnt1_q;
    logic          rvalid0_q;
    logic          rvalid1_q;
    logic [DW-1:0] rdata_q;
    logic          winner;

    // Under contention the port that did not win last time goes next.
    always_comb begin
        if (req0 && req1) begin
            winner = ~last_owner_q;
        end else begin
            winner = req1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            base_q       <= '0;
            beats_left_q <= 2'd0;
            beat_cnt_q   <= 2'd0;
            gnt0_q       <= 1'b0;
            gnt1_q       <= 1'b0;
            rvalid0_q    <= 1'b0;
            rvalid1_q    <= 1'b0;
            rdata_q      <= '0;
        end else begin
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (req0 || req1) begin
                        owner_q      <= winner;
                        last_owner_q <= winner;
                        base_q       <= winner ? addr1 : addr0;
                        beats_left_q <= winner ? len1 : len0;
                        beat_cnt_q   <= 2'd0;
                        gnt0_q       <= ~winner;
                        gnt1_q       <= winner;
                        state_q      <= StBurst;
                    end
                end
                StBurst: begin
                    // Memory is combinational, so the beat addressed this cycle is captured now.
                    rdata_q   <= mem_rdata;
                    rvalid0_q <= ~owner_q;
                    rvalid1_q <= owner_q;
                    if (beat_cnt_q == beats_left_q) begin
                        state_q <= StIdle;
                    end else begin
                        beat_cnt_q <= beat_cnt_q + 2'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Address arithmetic wraps naturally at the top of the AW-bit space.
    assign mem_addr = (state_q == StBurst) ? base_q + AW'(beat_cnt_q) : '0;
    assign busy     = (state_q == StBurst);
    assign gnt0     = gnt0_q;
    assign gnt1     = gnt1_q;
    assign rvalid0  = rvalid0_q;
    assign rvalid1  = rvalid1_q;
    assign rdata    = rdata_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: directed scenarios plus randomized traffic checked against a
// transaction-level round-robin / burst model over a bench-owned memory.
module tb_imem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1;
    logic [5:0]  addr0, addr1;
    logic [1:0]  len0, len1;
    logic        gnt0, gnt1;
    logic [5:0]  mem_addr;
    logic [31:0] mem_rdata;
    logic [31:0] rdata;
    logic        rvalid0, rvalid1;
    logic        busy;

    logic [31:0] mem [64];
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    imem_arbiter #(.AW(6), .DW(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .addr0     (addr0),
        .len0      (len0),
        .req1      (req1),
        .addr1     (addr1),
        .len1      (len1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .rdata     (rdata),
        .rvalid0   (rvalid0),
        .rvalid1   (rvalid1),
        .busy      (busy)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step;
        step;
        vectors++;
        if ({gnt0, gnt1, rvalid0, rvalid1, busy} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got %b want 00000", {gnt0, gnt1, rvalid0, rvalid1, busy});
        end
        vectors++;
        if (rdata !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_rdata: got %0d want 0", rdata);
        end
        vectors++;
        if (mem_addr !== 6'd0) begin
            miscompares++;
            $display("FAIL reset_mem_addr: got %0d want 0", mem_addr);
        end
        rst = 1'b0;
        step;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_single_burst;
        logic [31:0] exp_data [3];
        exp_data = '{32'd17, 32'd9, 32'd25};
        req0 = 1'b1; addr0 = 6'd0; len0 = 2'd2;
        step;
        req0 = 1'b0;
        vectors++;
        if ({gnt0, gnt1, busy, rvalid0} !== 4'b1010 || mem_addr !== 6'd0) begin
            miscompares++;
            $display("FAIL single_grant: got gnt0/gnt1/busy/rv0=%b addr=%0d want 1010 addr=0",
                     {gnt0, gnt1, busy, rvalid0}, mem_addr);
        end
        for (int i = 0; i < 3; i++) begin
            step;
            vectors++;
            if (rvalid0 !== 1'b1 || rvalid1 !== 1'b0 || gnt0 !== 1'b0 || rdata !== exp_data[i]) begin
                miscompares++;
                $display("FAIL single_beat%0d: got rv0=%b rv1=%b gnt0=%b rdata=%0d want 1 0 0 %0d",
                         i, rvalid0, rvalid1, gnt0, rdata, exp_data[i]);
            end
            vectors++;
            if (busy !== (i < 2) || mem_addr !== ((i < 2) ? 6'(i + 1) : 6'd0)) begin
                miscompares++;
                $display("FAIL single_busy%0d: got busy=%b addr=%0d want %b %0d", i, busy,
                         mem_addr, (i < 2), (i < 2) ? i + 1 : 0);
            end
        end
        step;
        vectors++;
        if (rvalid0 !== 1'b0 || rdata !== 32'd25) begin
            miscompares++;
            $display("FAIL single_hold: got rv0=%b rdata=%0d want 0 25", rvalid0, rdata);
        end
    endtask

    // Each entry: which ports request, expected winner; single-beat bursts, then one idle beat.
    task automatic test_contention;
        logic [1:0] reqs [5];
        int         exp_w [5];
        reqs  = '{2'b11, 2'b11, 2'b01, 2'b11, 2'b01};
        exp_w = '{0, 1, 0, 1, 0};
        rst = 1'b1;
        step;
        rst = 1'b0;
        addr0 = 6'd20; len0 = 2'd0; addr1 = 6'd30; len1 = 2'd0;
        req0 = 1'b0; req1 = 1'b0;
        // Entries 0/1: both request, port 1 keeps holding through port 0's burst.
        // Entries 3/4: port 0 holds through port 1's burst.
        for (int k = 0; k < 5; k++) begin
            if (k != 1 && k != 4) begin
                req0 = reqs[k][0];
                req1 = reqs[k][1];
            end
            step;
            vectors++;
            if (gnt0 !== (exp_w[k] == 0) || gnt1 !== (exp_w[k] == 1)) begin
                miscompares++;
                $display("FAIL contention_grant%0d: got gnt0=%b gnt1=%b want port %0d", k, gnt0,
                         gnt1, exp_w[k]);
            end
            if (exp_w[k] == 0) req0 = 1'b0;
            else req1 = 1'b0;
            step;
            vectors++;
            if (rdata !== ((exp_w[k] == 0) ? 32'd5000 : 32'd6000) ||
                rvalid0 !== (exp_w[k] == 0) || rvalid1 !== (exp_w[k] == 1)) begin
                miscompares++;
                $display("FAIL contention_data%0d: got rv0=%b rv1=%b rdata=%0d want port %0d",
                         k, rvalid0, rvalid1, rdata, exp_w[k]);
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        step;
    endtask

    task automatic test_wrap;
        req1 = 1'b1; addr1 = 6'd63; len1 = 2'd1;
        step;
        req1 = 1'b0;
        vectors++;
        if (gnt1 !== 1'b1 || gnt0 !== 1'b0 || mem_addr !== 6'd63) begin
            miscompares++;
            $display("FAIL wrap_grant: got gnt1=%b gnt0=%b addr=%0d want 1 0 63", gnt1, gnt0,
                     mem_addr);
        end
        step;
        vectors++;
        if (mem_addr !== 6'd0 || rvalid1 !== 1'b1 || rdata !== 32'd63) begin
            miscompares++;
            $display("FAIL wrap_beat0: got addr=%0d rv1=%b rdata=%0d want 0 1 63", mem_addr,
                     rvalid1, rdata);
        end
        step;
        vectors++;
        if (rvalid1 !== 1'b1 || rvalid0 !== 1'b0 || rdata !== 32'd17 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL wrap_beat1: got rv1=%b rv0=%b rdata=%0d busy=%b want 1 0 17 0",
                     rvalid1, rvalid0, rdata, busy);
        end
        step;
    endtask

    task automatic test_ignore_during_burst;
        req0 = 1'b1; addr0 = 6'd0; len0 = 2'd3;
        step;
        vectors++;
        if (gnt0 !== 1'b1) begin
            miscompares++;
            $display("FAIL ignore_gnt0: got %b want 1", gnt0);
        end
        // Late requester and a moved port-0 address must not disturb the running burst.
        req0 = 1'b0; addr0 = 6'd40;
        req1 = 1'b1; addr1 = 6'd20; len1 = 2'd0;
        for (int c = 2; c <= 7; c++) begin
            step;
            vectors++;
            if (rvalid0 !== (c >= 2 && c <= 5) || gnt1 !== (c == 6) || rvalid1 !== (c == 7) ||
                gnt0 !== 1'b0) begin
                miscompares++;
                $display("FAIL ignore_seq%0d: got rv0=%b gnt1=%b rv1=%b gnt0=%b", c, rvalid0,
                         gnt1, rvalid1, gnt0);
            end
            if (c <= 5) begin
                vectors++;
                if (rdata !== mem[c - 2]) begin
                    miscompares++;
                    $display("FAIL ignore_data%0d: got %0d want %0d", c, rdata, mem[c - 2]);
                end
            end
            if (c == 7) begin
                vectors++;
                if (rdata !== 32'd5000) begin
                    miscompares++;
                    $display("FAIL ignore_port1_data: got %0d want 5000", rdata);
                end
            end
            if (c == 6) req1 = 1'b0;
        end
    endtask

    task automatic test_reset_mid_burst;
        req0 = 1'b1; addr0 = 6'd0; len0 = 2'd3;
        step;
        req0 = 1'b0;
        step;
        rst = 1'b1;
        step;
        rst = 1'b0;
        vectors++;
        if ({gnt0, gnt1, rvalid0, rvalid1, busy} !== 5'b0 || rdata !== 32'd0 ||
            mem_addr !== 6'd0) begin
            miscompares++;
            $display("FAIL midrst_outputs: got flags=%b rdata=%0d addr=%0d want 0 0 0",
                     {gnt0, gnt1, rvalid0, rvalid1, busy}, rdata, mem_addr);
        end
        for (int c = 0; c < 6; c++) begin
            step;
            vectors++;
            if ({gnt0, gnt1, rvalid0, rvalid1, busy} !== 5'b0) begin
                miscompares++;
                $display("FAIL midrst_quiet%0d: got flags=%b want 00000", c,
                         {gnt0, gnt1, rvalid0, rvalid1, busy});
            end
        end
        req0 = 1'b1; addr0 = 6'd40; len0 = 2'd0;
        step;
        req0 = 1'b0;
        vectors++;
        if (gnt0 !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_regrant: got gnt0=%b want 1", gnt0);
        end
        step;
        vectors++;
        if (rvalid0 !== 1'b1 || rdata !== 32'd7000) begin
            miscompares++;
            $display("FAIL midrst_data: got rv0=%b rdata=%0d want 1 7000", rvalid0, rdata);
        end
    endtask

    task automatic test_back_to_back;
        int a;
        int ngnt;
        a = $urandom_range(63, 0);
        ngnt = 0;
        req0 = 1'b1; addr0 = 6'(a); len0 = 2'd0;
        for (int i = 1; i <= 12; i++) begin
            step;
            if (gnt0 === 1'b1) ngnt++;
            vectors++;
            if (gnt0 !== (i % 2 == 1)) begin
                miscompares++;
                $display("FAIL b2b_gnt%0d: got %b want %b", i, gnt0, (i % 2 == 1));
            end
            if (i % 2 == 0) begin
                vectors++;
                if (rvalid0 !== 1'b1 || rdata !== mem[a]) begin
                    miscompares++;
                    $display("FAIL b2b_data%0d: got rv0=%b rdata=%0d want 1 %0d", i, rvalid0,
                             rdata, mem[a]);
                end
            end
        end
        req0 = 1'b0;
        vectors++;
        if (ngnt !== 6) begin
            miscompares++;
            $display("FAIL b2b_count: got %0d grants want 6", ngnt);
        end
        step;
    endtask

    task automatic test_random;
        bit pend [2];
        int a [2];
        int l [2];
        int last;
        int w;
        int idx;
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        step;
        rst = 1'b0;
        last = 1;
        pend = '{1'b0, 1'b0};
        a = '{0, 0};
        l = '{0, 0};
        for (int t = 0; t < 60; t++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && ($urandom_range(1, 0) == 1 || (p == 1 && !pend[0]))) begin
                    pend[p] = 1'b1;
                    a[p] = $urandom_range(63, 0);
                    l[p] = $urandom_range(3, 0);
                end
            end
            req0 = pend[0]; addr0 = 6'(a[0]); len0 = 2'(l[0]);
            req1 = pend[1]; addr1 = 6'(a[1]); len1 = 2'(l[1]);
            w = (pend[0] && pend[1]) ? 1 - last : (pend[1] ? 1 : 0);
            step;
            vectors++;
            if (gnt0 !== (w == 0) || gnt1 !== (w == 1) || mem_addr !== 6'(a[w])) begin
                miscompares++;
                $display("FAIL rand_grant%0d: got gnt0=%b gnt1=%b addr=%0d want port %0d addr %0d",
                         t, gnt0, gnt1, mem_addr, w, a[w]);
            end
            last = w;
            pend[w] = 1'b0;
            if (w == 0) req0 = 1'b0;
            else req1 = 1'b0;
            for (int i = 0; i <= l[w]; i++) begin
                step;
                idx = (a[w] + i) % 64;
                vectors++;
                if (rvalid0 !== (w == 0) || rvalid1 !== (w == 1) || rdata !== mem[idx]) begin
                    miscompares++;
                    $display("FAIL rand_beat%0d_%0d: got rv0=%b rv1=%b rdata=%0d want port %0d %0d",
                             t, i, rvalid0, rvalid1, rdata, w, mem[idx]);
                end
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        step;
    endtask

    initial begin
        rst = 1'b1;
        req0 = 1'b0; addr0 = 6'd0; len0 = 2'd0;
        req1 = 1'b0; addr1 = 6'd0; len1 = 2'd0;
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        mem[0] = 32'd17; mem[1] = 32'd9; mem[2] = 32'd25;
        mem[20] = 32'd5000; mem[30] = 32'd6000; mem[40] = 32'd7000; mem[63] = 32'd63;
        test_reset;
        test_single_burst;
        test_contention;
        test_wrap;
        test_ignore_during_burst;
        test_reset_mid_burst;
        test_back_to_back;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 Parameter AW, default 6, memory word-address width (64 words).
REQ-002 Parameter DW, default 32, memory data width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req0  input  1  requester 0 (fetch) burst request; held until gnt0.
REQ-006 addr0  input  AW  requester 0 burst start address; stable while req0=1.
REQ-007 len0  input  2  requester 0 burst length minus one (1..4 beats).
REQ-008 req1, addr1, len1  input  1/AW/2  requester 1 (load/debug), same meaning as port 0.
REQ-009 gnt0, gnt1  output  1 each  one-cycle grant pulse at first beat of granted burst.
REQ-010 mem_addr  output  AW  address driven to the combinational-read memory.
REQ-011 mem_rdata  input  DW  memory read data, valid same cycle as mem_addr.
REQ-012 rdata  output  DW  registered read data, shared by both requesters.
REQ-013 rvalid0, rvalid1  output  1 each  rdata holds a beat for that requester.
REQ-014 busy  output  1  high while a burst is in progress (state BURST).

Function
REQ-015 FSM shall have two states: IDLE, BURST; reset state IDLE.
REQ-016 In IDLE with any req high at a rising edge, block shall select owner, latch owner's addr/len into base and beats-left registers, zero beat counter, enter BURST.
REQ-017 Arbitration shall be round-robin: only one req -> that port wins; both -> port not equal to last_owner wins; last_owner updates on every grant.
REQ-018 last_owner shall reset to 1 so port 0 wins first contention after reset.
REQ-019 gnt<owner> shall be high exactly in the first BURST cycle; the other gnt stays 0.
REQ-020 In BURST, mem_addr shall equal base + beat counter, modulo 2^AW (63 -> 0 wrap); mem_addr shall be 0 in IDLE.
REQ-021 Each BURST cycle, rdata shall register mem_rdata and rvalid<owner> shall be 1 in the following cycle; latency request edge -> first rvalid = 2 cycles.
REQ-022 Burst of len+1 beats shall produce exactly len+1 consecutive rvalid pulses, in ascending (wrapped) address order.
REQ-023 After the last beat address cycle, FSM shall return to IDLE; at least one IDLE cycle separates bursts.
REQ-024 A requester still asserting req in IDLE after its burst shall be re-arbitrated as a new request (requester must drop req after gnt).
REQ-025 req/addr/len changes during BURST shall be ignored; pending requests wait until IDLE.
REQ-026 rdata shall hold its last value when no rvalid is asserted; rvalid0 and rvalid1 never both high.

Reset
REQ-027 On rst=1 at a rising edge: state IDLE, gnt0=gnt1=0, rvalid0=rvalid1=0, busy=0, rdata=0, mem_addr=0, beat counter=0, last_owner=1.
REQ-028 Reset mid-burst shall abandon the burst; no rvalid pulses for remaining beats after rst deasserts, and no grant is replayed.

Verification (bench memory preloaded mem[0]=17, mem[1]=9, mem[2]=25, mem[20]=5000, mem[30]=6000, mem[40]=7000, mem[63]=63)
REQ-029 req0, addr0=0, len0=2 at edge k -> gnt0 at k+1, rvalid0 at k+2..k+4 with rdata 17, 9, 25; busy k+1..k+3.
REQ-030 req0 and req1 both high in same cycle after reset (addr0=20, addr1=30, len=0) -> port 0 granted first (rdata 5000), then port 1 (rdata 6000); next simultaneous contention grants port 0 again only after port 1 won.
REQ-031 req1, addr1=63, len1=1 -> mem_addr 63 then 0, rvalid1 twice with rdata 63, 17.
REQ-032 req1 rises during port 0 4-beat burst -> port 1 ignored until IDLE, then granted; rvalid0 and rvalid1 never overlap.
REQ-033 rst asserted during beat 2 of a 4-beat burst -> all outputs 0 next cycle, no further rvalid; fresh req0 addr0=40 len0=0 afterwards -> rdata 7000 at latency 2.
REQ-034 req0 held high continuously with len0=0 -> repeated single-beat bursts every 2 cycles, one gnt0 per burst.
